alu_cmd_queue: RTL and testbench

Registered command/result stage wrapped around the combinational ALU. It buffers incoming ALU commands (op, a, b, tag) in a small FIFO and presents the head entry to the ALU. It captures the ALU result into an output register with its tag, using valid/ready handshakes on both sides. It is the sequential front/back end the core uses in place of driving the ALU directly.

---
 rtl/alu_cmd_queue.sv | 123 ++++++++++++
 tb/tb_alu_cmd_queue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command FIFO in front of a combinational ALU plus a registered
// result stage with its tag. valid/ready handshakes on both sides.
// Optional build macro ALU_CMD_QUEUE_ILLEGAL_OP_EN adds out_err, which flags
// op encodings >= 10 and zeroes the captured result for them.
module alu_cmd_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic [3:0]           alu_op,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  input  logic [WIDTH-1:0]     alu_x,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_x,
`ifdef ALU_CMD_QUEUE_ILLEGAL_OP_EN
  output logic                 out_err,
`endif
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [3:0]  OP_ADD = 4'd0;
  localparam logic [3:0]  OP_FIRST_ILLEGAL = 4'd10;

  typedef struct packed {
    logic [3:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [TAG_WIDTH-1:0] tag;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             push;
  logic             advance;

  assign empty    = (count == '0);
  assign in_ready = (count != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  // A freshly pushed entry is only visible once count is updated, so an
  // empty queue never captures in the same cycle it is written.
  assign advance  = !empty && (!out_valid || out_ready);
  assign head     = mem[rd_ptr];

  // Present the head command to the ALU; idle as ADD 0,0 when empty.
  always_comb begin
    alu_op = OP_ADD;
    alu_a  = '0;
    alu_b  = '0;
    if (!empty) begin
      alu_op = head.op;
      alu_a  = head.a;
      alu_b  = head.b;
    end
  end

  // Storage array; contents survive reset but are unreachable afterwards.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (advance) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, advance})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Result register: load on advance, release valid when drained and empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_tag   <= '0;
`ifdef ALU_CMD_QUEUE_ILLEGAL_OP_EN
      out_err   <= 1'b0;
`endif
    end else if (advance) begin
      out_valid <= 1'b1;
      out_tag   <= head.tag;
`ifdef ALU_CMD_QUEUE_ILLEGAL_OP_EN
      out_err   <= (head.op >= OP_FIRST_ILLEGAL);
      out_x     <= (head.op >= OP_FIRST_ILLEGAL) ? '0 : alu_x;
`else
      out_x     <= alu_x;
`endif
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue with an attached behavioural ALU.
module tb_alu_cmd_queue;

  localparam int unsigned DEPTH     = 4;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned TAG_WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [3:0]           in_op;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic [TAG_WIDTH-1:0] in_tag;
  logic [3:0]           alu_op;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [WIDTH-1:0]     alu_x;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_x;
  logic [TAG_WIDTH-1:0] out_tag;
`ifdef ALU_CMD_QUEUE_ILLEGAL_OP_EN
  logic                 out_err;
`endif

  alu_cmd_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_x     (alu_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
`ifdef ALU_CMD_QUEUE_ILLEGAL_OP_EN
    .out_err   (out_err),
`endif
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; unused encodings return a^b so pass-through is observable.
  always_comb begin
    case (alu_op)
      4'd0:    alu_x = alu_a + alu_b;
      4'd1:    alu_x = alu_a - alu_b;
      4'd2:    alu_x = alu_a & alu_b;
      4'd3:    alu_x = alu_a | alu_b;
      4'd4:    alu_x = alu_a ^ alu_b;
      4'd5:    alu_x = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'd6:    alu_x = {31'd0, alu_a < alu_b};
      4'd7:    alu_x = alu_a << alu_b[4:0];
      4'd8:    alu_x = alu_a >> alu_b[4:0];
      4'd9:    alu_x = $signed(alu_a) >>> alu_b[4:0];
      default: alu_x = alu_a ^ alu_b;
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0]     x;
    logic [TAG_WIDTH-1:0] tag;
    logic                 err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   rand_ready = 1'b0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Monitor: a result is consumed at the next edge when valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got tag %h x %h, expected no result", out_tag, out_x);
      end else begin
        e = sb.pop_front();
        check("result_x", out_x, e.x);
        check("result_tag", WIDTH'(out_tag), WIDTH'(e.tag));
`ifdef ALU_CMD_QUEUE_ILLEGAL_OP_EN
        check("result_err", WIDTH'(out_err), WIDTH'(e.err));
`endif
      end
    end
  end

  // Random consumer backpressure while enabled.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one command (called at posedge+1); returns at posedge+1 after acceptance.
  task automatic push(input logic [3:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic [TAG_WIDTH-1:0] tag,
                      input logic [WIDTH-1:0] x, input logic err);
    int waited = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL push_timeout: got in_ready=0 for tag %h, expected acceptance", tag);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      @(posedge clk);
      sb.push_back('{x: x, tag: tag, err: err});
      #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      waited++;
      tick(1);
    end
    check("drain_empty", WIDTH'(sb.size()), '0);
  endtask

  // Wrap-around vectors with hand-computed results.
  logic [3:0]       v_op [20] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
                                  4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd4, 4'd2, 4'd7};
  logic [WIDTH-1:0] v_a  [20] = '{32'hFFFFFFFF, 32'h00000003, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                  32'hAAAAAAAA, 32'h80000000, 32'h80000000, 32'h00000001,
                                  32'h80000000, 32'h80000000, 32'h12345678, 32'h00000010,
                                  32'h00000005, 32'h00000005, 32'h0000000F, 32'hF0000000,
                                  32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'h00000003};
  logic [WIDTH-1:0] v_b  [20] = '{32'h00000001, 32'h00000005, 32'h0FF00FF0, 32'h0F0F0000,
                                  32'hFFFF0000, 32'h00000001, 32'h00000001, 32'h0000001F,
                                  32'h00000004, 32'h00000004, 32'h11111111, 32'h00000010,
                                  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000004, 32'h0000001C,
                                  32'h00000004, 32'h12345678, 32'h0000FFFF, 32'h00000021};
  logic [WIDTH-1:0] v_x  [20] = '{32'h00000000, 32'hFFFFFFFE, 32'h00F000F0, 32'hFFFFF0F0,
                                  32'h5555AAAA, 32'h00000001, 32'h00000000, 32'h80000000,
                                  32'h08000000, 32'hF8000000, 32'h23456789, 32'h00000000,
                                  32'h00000000, 32'h00000001, 32'h000000F0, 32'h0000000F,
                                  32'h07FFFFFF, 32'h00000000, 32'h0000FFFF, 32'h00000006};

  initial begin
    logic [WIDTH-1:0] held_x;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;

    // Reset state and idle ALU drive.
    #1;
    check("rst_out_valid", WIDTH'(out_valid), '0);
    check("rst_out_x", out_x, '0);
    check("rst_out_tag", WIDTH'(out_tag), '0);
    check("rst_in_ready", WIDTH'(in_ready), 32'd1);
    check("idle_alu_op", WIDTH'(alu_op), '0);
    check("idle_alu_a", alu_a, '0);
    check("idle_alu_b", alu_b, '0);
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD: not visible at the accepting edge, valid one edge later.
    push(4'd0, 32'h5, 32'h3, 4'h1, 32'h8, 1'b0);
    idle();
    check("add_no_passthrough", WIDTH'(out_valid), '0);
    tick(1);
    check("add_latency_valid", WIDTH'(out_valid), 32'd1);
    check("add_latency_x", out_x, 32'h8);
    check("add_latency_tag", WIDTH'(out_tag), 32'h1);
    wait_drain();

    // Reset mid-burst discards queued and held commands.
    out_ready = 1'b0;
    push(4'd0, 32'h1, 32'h1, 4'hA, 32'h2, 1'b0);
    push(4'd0, 32'h2, 32'h2, 4'hB, 32'h4, 1'b0);
    push(4'd0, 32'h3, 32'h3, 4'hC, 32'h6, 1'b0);
    idle();
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", WIDTH'(out_valid), '0);
    check("midrst_in_ready", WIDTH'(in_ready), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick(5);
    check("midrst_no_stale", WIDTH'(out_valid), '0);

    // Backpressure until full; held result must stay stable.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(4'd0, 32'h100 + 32'(i), 32'(i), 4'(i), 32'h100 + 32'(2 * i), 1'b0);
    end
    check("full_in_ready", WIDTH'(in_ready), '0);
    in_valid = 1'b1;
    in_op    = 4'd0;
    in_a     = 32'h105;
    in_b     = 32'h5;
    in_tag   = 4'h5;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("full_hold_ready", WIDTH'(in_ready), '0);
      check("full_hold_x", out_x, 32'h100);
      check("full_hold_tag", WIDTH'(out_tag), '0);
    end
    out_ready = 1'b1;
    push(4'd0, 32'h105, 32'h5, 4'h5, 32'h10A, 1'b0);
    idle();
    wait_drain();

    // Simultaneous push and capture at DEPTH-1 keeps in_ready high.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push(4'd1, 32'h50, 32'(i), 4'(8 + i), 32'h50 - 32'(i), 1'b0);
    end
    idle();
    check("dm1_in_ready_before", WIDTH'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push(4'd3, 32'h0, 32'(1 << i), 4'(12 + i), 32'(1 << i), 1'b0);
      check("dm1_in_ready", WIDTH'(in_ready), 32'd1);
    end
    idle();
    wait_drain();

    // Wrap-around with random consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      push(v_op[i], v_a[i], v_b[i], 4'(i), v_x[i], 1'b0);
    end
    idle();
    tick(1);
    rand_ready = 1'b0;
    tick(1);
    out_ready = 1'b1;
    wait_drain();

    // Op 12 then ADD: flagged and zeroed with the feature, passed through without.
`ifdef ALU_CMD_QUEUE_ILLEGAL_OP_EN
    push(4'd12, 32'hF0, 32'h0F, 4'h7, 32'h0, 1'b1);
    idle();
    tick(1);
    check("illegal_err", WIDTH'(out_err), 32'd1);
    check("illegal_x", out_x, '0);
`else
    push(4'd12, 32'hF0, 32'h0F, 4'h7, 32'hFF, 1'b0);
    idle();
    tick(1);
    check("op12_passthrough_x", out_x, 32'hFF);
`endif
    push(4'd0, 32'h1, 32'h1, 4'h8, 32'h2, 1'b0);
    idle();
    tick(1);
`ifdef ALU_CMD_QUEUE_ILLEGAL_OP_EN
    check("legal_err_clear", WIDTH'(out_err), '0);
`endif
    check("after_op12_x", out_x, 32'h2);
    wait_drain();
    tick(2);
    held_x = out_x;
    check("final_idle_valid", WIDTH'(out_valid), '0);
    check("final_x_held", held_x, 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1);
  end

endmodule
